// File: rtl/smart_home_pkg.sv
// Shared types and constants for the smart-home climate blocks.
package smart_home_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEAT    = 2'd1,
    COOL    = 2'd2,
    LOCKOUT = 2'd3
  } hvac_state_t;

  localparam int HOURS_PER_DAY = 24;
  localparam int TEMP_W        = 5;
endpackage

// File: rtl/hvac_scheduler_hour_clock.sv
// Hour-of-day clock: divides the external tick into hours and decodes daytime.
module hour_clock
  import smart_home_pkg::*;
#(
  parameter int TICKS_PER_HOUR = 60,
  parameter int DAY_START      = 7,
  parameter int NIGHT_START    = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  output logic [4:0] hour,
  output logic       day,
  output logic       hour_inc
);
  localparam int PW = (TICKS_PER_HOUR > 1) ? $clog2(TICKS_PER_HOUR) : 1;

  logic [PW-1:0] presc;

  // The tick that would complete the hour advances it instead of being counted.
  assign hour_inc = tick && (presc == PW'(TICKS_PER_HOUR - 1));
  assign day      = (hour >= 5'(DAY_START)) && (hour < 5'(NIGHT_START));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      hour  <= '0;
    end else if (tick) begin
      if (hour_inc) begin
        presc <= '0;
        hour  <= (hour == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : hour + 5'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end
endmodule

// File: rtl/hvac_scheduler.sv
// Heating/cooling sequencer: day/night/boost setpoint, hysteresis FSM with
// minimum-on and lockout timing, and an overtemperature trip to cooling.
module hvac_scheduler
  import smart_home_pkg::*;
#(
  parameter int TICKS_PER_HOUR = 60,
  parameter int DAY_START      = 7,
  parameter int NIGHT_START    = 22,
  parameter int DAY_SP         = 20,
  parameter int NIGHT_SP       = 16,
  parameter int HYST           = 2,
  parameter int MIN_ON         = 5,
  parameter int MIN_OFF        = 3,
  parameter int BOOST_HOURS    = 2,
  parameter int TEMP_MAX       = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [TEMP_W-1:0] temperature,
  input  logic              boost,
  output logic              heating,
  output logic              cooling,
  output logic [TEMP_W-1:0] setpoint,
  output logic [4:0]        hour,
  output logic              day,
  output logic              boost_active,
  output logic [1:0]        state
);
  localparam int ON_W  = (MIN_ON > 0) ? $clog2(MIN_ON + 1) : 1;
  localparam int OFF_W = (MIN_OFF > 0) ? $clog2(MIN_OFF + 1) : 1;
  localparam int BW    = (BOOST_HOURS > 0) ? $clog2(BOOST_HOURS + 1) : 1;

  function automatic logic [TEMP_W-1:0] sat_sub(input logic [TEMP_W-1:0] a, input int b);
    int d;
    d = int'(a) - b;
    if (d < 0) return '0;
    return TEMP_W'(d);
  endfunction

  function automatic logic [TEMP_W-1:0] sat_add(input logic [TEMP_W-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s > (1 << TEMP_W) - 1) return '1;
    return TEMP_W'(s);
  endfunction

  logic              hour_inc;
  logic [BW-1:0]     boost_cnt;
  logic [TEMP_W-1:0] lo, hi;
  logic              over;
  hvac_state_t       st_q, st_d;
  logic [ON_W-1:0]   on_q, on_d;
  logic [OFF_W-1:0]  off_q, off_d;

  hour_clock #(
    .TICKS_PER_HOUR(TICKS_PER_HOUR),
    .DAY_START     (DAY_START),
    .NIGHT_START   (NIGHT_START)
  ) u_hour_clock (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .hour    (hour),
    .day     (day),
    .hour_inc(hour_inc)
  );

  // A boost request reloads the counter even on an hour boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      boost_cnt    <= '0;
      boost_active <= 1'b0;
    end else if (boost) begin
      boost_cnt    <= BW'(BOOST_HOURS);
      boost_active <= (BOOST_HOURS != 0);
    end else if (hour_inc && boost_active) begin
      boost_cnt <= boost_cnt - 1'b1;
      if (boost_cnt == BW'(1)) boost_active <= 1'b0;
    end
  end

  assign setpoint = (day || boost_active) ? TEMP_W'(DAY_SP) : TEMP_W'(NIGHT_SP);
  assign lo       = sat_sub(setpoint, HYST);
  assign hi       = sat_add(setpoint, HYST);
  assign over     = temperature >= TEMP_W'(TEMP_MAX);

  always_comb begin
    st_d  = st_q;
    on_d  = on_q;
    off_d = off_q;
    case (st_q)
      IDLE: begin
        on_d = '0;
        if (over)                    st_d = COOL;
        else if (temperature <= lo)  st_d = HEAT;
        else if (temperature >= hi)  st_d = COOL;
      end
      HEAT: begin
        // Overtemperature abandons heating without waiting out the on-time.
        if (over || (temperature >= setpoint && on_q == ON_W'(MIN_ON))) begin
          st_d  = LOCKOUT;
          off_d = '0;
        end else if (tick && on_q != ON_W'(MIN_ON)) begin
          on_d = on_q + 1'b1;
        end
      end
      COOL: begin
        if (!over && temperature <= setpoint && on_q == ON_W'(MIN_ON)) begin
          st_d  = LOCKOUT;
          off_d = '0;
        end else if (tick && on_q != ON_W'(MIN_ON)) begin
          on_d = on_q + 1'b1;
        end
      end
      LOCKOUT: begin
        if (off_q == OFF_W'(MIN_OFF))  st_d  = IDLE;
        else if (tick)                 off_d = off_q + 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      on_q    <= '0;
      off_q   <= '0;
      heating <= 1'b0;
      cooling <= 1'b0;
    end else begin
      st_q    <= st_d;
      on_q    <= on_d;
      off_q   <= off_d;
      heating <= (st_d == HEAT);
      cooling <= (st_d == COOL);
    end
  end

  assign state = st_q;
endmodule
